hrange_sum: RTL and testbench

Consumer-side caller for the generator handshake (`_start` / `_wait` / `_valid` / `_ready`). It accepts `(base, limit, step)`, invokes one internal `hrange` generator instance and drains every value that instance yields. It re-yields each value together with a running sum and an index, through a one-entry output register with downstream back-pressure. It sits where generated code calls a sub-generator and post-processes its stream.

---
 rtl/hrange_sum_pkg.sv | 28 ++
 rtl/hrange_sum_hrange.sv | 58 +++++
 rtl/hrange_sum.sv | 106 ++++++++++
 tb/tb_hrange_sum.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hrange_sum_pkg.sv
// Shared types for the hrange_sum caller and its inner hrange generator.
// Values are signed two's complement words; range checks use one extra bit.
package hrange_sum_pkg;

  localparam int unsigned WIDTH = 32;

  typedef logic signed [WIDTH-1:0] word_t;
  typedef logic signed [WIDTH:0]   wide_t;

  typedef enum logic [1:0] {
    StIdle,
    StCall,
    StRecv,
    StDrain
  } state_e;

  // True while v lies strictly before limit in the direction of step; step 0 is never in range.
  function automatic logic in_range(wide_t v, word_t lim, word_t stp);
    logic stp_neg;
    logic stp_pos;
    stp_neg = stp[WIDTH-1];
    stp_pos = !stp[WIDTH-1] && (stp != '0);
    if (stp_pos) return v < wide_t'(lim);
    if (stp_neg) return v > wide_t'(lim);
    return 1'b0;
  endfunction

endpackage

// File: rtl/hrange_sum_hrange.sv
// Inner generator: yields base, base+step, ... while strictly short of limit.
// Uses the _start/_wait/_valid/_ready handshake with registered outputs.
module hrange
  import hrange_sum_pkg::*;
(
  input  logic  _clock,
  input  logic  _reset,
  input  logic  _start,
  input  logic  _wait,
  input  word_t base,
  input  word_t limit,
  input  word_t step,
  output logic  _ready,
  output logic  _valid,
  output word_t _0
);

  word_t limit_q, step_q, v_q;
  logic  ready_q, valid_q;
  wide_t next_w;
  logic  first_ok;

  // Extra bit keeps the next value comparable even when it leaves the word range.
  assign next_w   = wide_t'(v_q) + wide_t'(step_q);
  assign first_ok = in_range(wide_t'(base), limit, step);

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      v_q     <= '0;
      limit_q <= '0;
      step_q  <= '0;
    end else if (ready_q) begin
      if (_start) begin
        limit_q <= limit;
        step_q  <= step;
        v_q     <= base;
        if (first_ok) begin
          ready_q <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end else if (valid_q && !_wait) begin
      if (in_range(next_w, limit_q, step_q)) begin
        v_q <= next_w[WIDTH-1:0];
      end else begin
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end
    end
  end

  assign _ready = ready_q;
  assign _valid = valid_q;
  assign _0     = v_q;

endmodule

// File: rtl/hrange_sum.sv
// Calls one hrange generator and re-yields each value with a running sum and
// index through a one-entry output register that honours downstream _wait.
module hrange_sum
  import hrange_sum_pkg::*;
(
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic             _wait,
  input  word_t            base,
  input  word_t            limit,
  input  word_t            step,
  output logic             _ready,
  output logic             _valid,
  output word_t            _0,
  output word_t            _1,
  output logic [WIDTH-1:0] _2
);

  state_e           state_q;
  word_t            base_q, limit_q, step_q, v_q, sum_q;
  logic [WIDTH-1:0] idx_q, idx_out_q;
  logic             ready_q, valid_q, call_q;

  logic  h_ready, h_valid, h_wait, take;
  word_t h_v;

  assign h_wait = valid_q & _wait;
  assign take   = (state_q == StRecv) & h_valid & ~h_wait;

  hrange u_hrange (
    ._clock (_clock),
    ._reset (_reset),
    ._start (call_q),
    ._wait  (h_wait),
    .base   (base_q),
    .limit  (limit_q),
    .step   (step_q),
    ._ready (h_ready),
    ._valid (h_valid),
    ._0     (h_v)
  );

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q   <= StIdle;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      call_q    <= 1'b0;
      base_q    <= '0;
      limit_q   <= '0;
      step_q    <= '0;
      v_q       <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      idx_out_q <= '0;
    end else begin
      call_q <= 1'b0;
      if (take) begin
        v_q       <= h_v;
        sum_q     <= sum_q + h_v;
        idx_out_q <= idx_q;
        idx_q     <= idx_q + WIDTH'(1);
        valid_q   <= 1'b1;
      end else if (valid_q && !_wait) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (_start) begin
            base_q  <= base;
            limit_q <= limit;
            step_q  <= step;
            sum_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            call_q  <= (step != '0);
            state_q <= StCall;
          end
        end
        StCall: begin
          // A zero step never invokes the generator.
          state_q <= (step_q == '0) ? StDrain : StRecv;
        end
        StRecv: begin
          if (h_ready) state_q <= StDrain;
        end
        StDrain: begin
          if (!valid_q || !_wait) begin
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign _ready = ready_q;
  assign _valid = valid_q;
  assign _0     = v_q;
  assign _1     = sum_q;
  assign _2     = idx_out_q;

endmodule

// File: tb/tb_hrange_sum.sv
// Randomised and directed bench for hrange_sum against a queue-based range/sum model.
module tb_hrange_sum;
  import hrange_sum_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             wt = 1'b0;
  word_t            base = '0, limit = '0, step = '0;
  logic             rdy, vld;
  word_t            o0, o1;
  logic [WIDTH-1:0] o2;

  int checks = 0;
  int failures = 0;

  typedef struct {int v; int s; int i;} tup_t;
  tup_t expq[$];
  int   logv[$];
  int   logs[$];
  int   wmode = 0;
  int   stalls = 0;
  int   stall2 = 0;
  int   vcycles = 0;
  int   exp_sum = 0;

  always #5 clk = ~clk;

  hrange_sum dut (
    ._clock (clk),
    ._reset (rst),
    ._start (start),
    ._wait  (wt),
    .base   (base),
    .limit  (limit),
    .step   (step),
    ._ready (rdy),
    ._valid (vld),
    ._0     (o0),
    ._1     (o1),
    ._2     (o2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_seq(input string name, input int act[$], input int exp[$]);
    chk({name, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++) chk(name, act[i], exp[i]);
  endtask

  // Reference: every value of the range, in order, with wrapped running sum and index.
  task automatic build_exp(input int b, input int l, input int s);
    longint v;
    int     sum;
    int     idx;
    tup_t   t;
    expq.delete();
    logv.delete();
    logs.delete();
    vcycles = 0;
    sum = 0;
    idx = 0;
    v = b;
    while (((s > 0) && (v < l)) || ((s < 0) && (v > l))) begin
      sum += int'(v);
      t.v = int'(v);
      t.s = sum;
      t.i = idx;
      expq.push_back(t);
      idx++;
      v += s;
    end
    exp_sum = sum;
  endtask

  task automatic run_call(input int b, input int l, input int s, input bit poke,
                          output int ncyc);
    int n;
    build_exp(b, l, s);
    n = 0;
    while (!rdy && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    base = b; limit = l; step = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_low_after_accept", int'(rdy), 0);
    n = 0;
    while (!rdy && n < 1000) begin
      if (poke && n == 2) begin
        start = 1'b1; base = 100; limit = 200; step = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("call_completes", int'(n < 1000), 1);
    chk("all_tuples_drained", expq.size(), 0);
    chk("final_sum", o1, exp_sum);
    ncyc = n;
  endtask

  // Compare process: every presented tuple must match the head of the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld) vcycles++;
      if (vld && rdy) chk("valid_ready_exclusive", 1, 0);
      if (vld) begin
        if (expq.size() == 0) begin
          chk("unexpected_tuple", 1, 0);
        end else begin
          chk("tuple_v", o0, expq[0].v);
          chk("tuple_sum", o1, expq[0].s);
          chk("tuple_idx", int'(o2), expq[0].i);
          chk("inner_wait", int'(dut.u_hrange._wait), int'(wt));
          if (wt) begin
            if (o0 == 2 && wmode == 2) stall2++;
          end else begin
            logv.push_back(o0);
            logs.push_back(o1);
            void'(expq.pop_front());
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (wmode)
      0: wt = 1'b0;
      1: wt = ($urandom_range(0, 1) == 1);
      default: begin
        if (vld && o0 == 2 && stalls < 3) begin
          wt = 1'b1;
          stalls++;
        end else begin
          wt = 1'b0;
        end
      end
    endcase
  end

  initial begin
    int n;
    int ev[$];
    int es[$];
    int b, l, s;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", int'(rdy), 1);
    chk("reset_valid", int'(vld), 0);
    chk("reset_o0", o0, 0);
    chk("reset_o1", o1, 0);
    chk("reset_o2", int'(o2), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    wmode = 0;
    run_call(0, 10, 2, 1'b0, n);
    ev = '{0, 2, 4, 6, 8};
    es = '{0, 2, 6, 12, 20};
    chk_seq("seq_0_10_2_v", logv, ev);
    chk_seq("seq_0_10_2_sum", logs, es);
    chk("valid_cycles_0_10_2", vcycles, 5);

    run_call(10, 0, -3, 1'b1, n);
    ev = '{10, 7, 4, 1};
    es = '{10, 17, 21, 22};
    chk_seq("seq_10_0_m3_v", logv, ev);
    chk_seq("seq_10_0_m3_sum", logs, es);

    run_call(5, 5, 1, 1'b0, n);
    chk("empty_range_no_valid", vcycles, 0);

    run_call(0, 10, 0, 1'b0, n);
    chk("zero_step_no_valid", vcycles, 0);
    chk("zero_step_latency", n, 2);

    wmode = 2;
    stalls = 0;
    stall2 = 0;
    run_call(0, 10, 2, 1'b0, n);
    ev = '{0, 2, 4, 6, 8};
    chk_seq("seq_stall_v", logv, ev);
    chk("stall_cycles_at_2", stall2, 3);
    wmode = 0;

    run_call(1500000000, 1500000002, 1, 1'b0, n);
    es = '{1500000000, -1294967295};
    chk_seq("seq_wrap_sum", logs, es);

    // Reset while the third tuple is presented.
    build_exp(0, 10, 2);
    base = 0; limit = 10; step = 2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(vld && o0 == 4) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("third_tuple_seen", int'(n < 100), 1);
    rst = 1'b1;
    #1;
    chk("midreset_ready", int'(rdy), 1);
    chk("midreset_valid", int'(vld), 0);
    chk("midreset_o0", o0, 0);
    chk("midreset_o1", o1, 0);
    chk("midreset_o2", int'(o2), 0);
    chk("midreset_inner_ready", int'(dut.u_hrange._ready), 1);
    #2;
    rst = 1'b0;
    expq.delete();
    @(posedge clk); #1;
    run_call(1, 4, 1, 1'b0, n);
    ev = '{1, 2, 3};
    es = '{1, 3, 6};
    chk_seq("seq_after_reset_v", logv, ev);
    chk_seq("seq_after_reset_sum", logs, es);

    wmode = 1;
    for (int k = 0; k < 12; k++) begin
      b = int'($urandom_range(0, 60)) - 30;
      l = int'($urandom_range(0, 60)) - 30;
      s = int'($urandom_range(0, 10)) - 5;
      run_call(b, l, s, k[0], n);
    end
    wmode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
